// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one synchronous single-port memory between a fetch port and a data port.
// Every access spends one ISSUE cycle on the memory; a read adds one WAIT cycle while the memory registers its data.
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_dataOutput,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic              prio_data, prio_data_next;
    logic              port_data, port_data_next;
    logic              is_write, is_write_next;
    logic              pick_data;
    logic              take_write;

    logic              f_gnt_next, d_gnt_next;
    logic              f_rvalid_next, d_rvalid_next;
    logic              mem_read_next, mem_write_next;
    logic [ADDR_W-1:0] address_next;
    logic [DATA_W-1:0] write_data_next;
    logic [DATA_W-1:0] f_rdata_next, d_rdata_next;

    // prio_data set means the fetch port was granted last, so data wins the next tie.
    assign pick_data  = d_req & (~f_req | prio_data);
    assign take_write = pick_data & d_we;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next      = state;
        prio_data_next  = prio_data;
        port_data_next  = port_data;
        is_write_next   = is_write;
        f_gnt_next      = 1'b0;
        d_gnt_next      = 1'b0;
        f_rvalid_next   = 1'b0;
        d_rvalid_next   = 1'b0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        address_next    = mem_address;
        write_data_next = mem_writeData;
        f_rdata_next    = f_rdata;
        d_rdata_next    = d_rdata;

        case (state)
            IDLE: begin
                if (f_req || d_req) begin
                    state_next     = ISSUE;
                    port_data_next = pick_data;
                    is_write_next  = take_write;
                    prio_data_next = ~pick_data;
                    mem_read_next  = ~take_write;
                    mem_write_next = take_write;
                    if (pick_data) begin
                        d_gnt_next      = 1'b1;
                        address_next    = d_addr;
                        write_data_next = d_wdata;
                    end else begin
                        f_gnt_next   = 1'b1;
                        address_next = f_addr;
                    end
                end
            end

            ISSUE: begin
                state_next = is_write ? IDLE : WAIT;
            end

            // The memory registered the read word at the end of ISSUE; hand it to the winner.
            WAIT: begin
                state_next = IDLE;
                if (port_data) begin
                    d_rdata_next  = mem_dataOutput;
                    d_rvalid_next = 1'b1;
                end else begin
                    f_rdata_next  = mem_dataOutput;
                    f_rvalid_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            prio_data     <= 1'b0;
            port_data     <= 1'b0;
            is_write      <= 1'b0;
            f_gnt         <= 1'b0;
            d_gnt         <= 1'b0;
            f_rvalid      <= 1'b0;
            d_rvalid      <= 1'b0;
            mem_memRead   <= 1'b0;
            mem_memWrite  <= 1'b0;
            mem_address   <= '0;
            mem_writeData <= '0;
            f_rdata       <= '0;
            d_rdata       <= '0;
        end else begin
            prio_data     <= prio_data_next;
            port_data     <= port_data_next;
            is_write      <= is_write_next;
            f_gnt         <= f_gnt_next;
            d_gnt         <= d_gnt_next;
            f_rvalid      <= f_rvalid_next;
            d_rvalid      <= d_rvalid_next;
            mem_memRead   <= mem_read_next;
            mem_memWrite  <= mem_write_next;
            mem_address   <= address_next;
            mem_writeData <= write_data_next;
            f_rdata       <= f_rdata_next;
            d_rdata       <= d_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural memory plus a transaction-level model that predicts
// grant order, grant/rvalid cycles and read data from the round-robin and latency rules.
module tb_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              clear_n = 1'b0;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_gnt, f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memRead, mem_memWrite;
    logic [DATA_W-1:0] mem_dataOutput = '0;
    logic              busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                fetch_next;
    logic [DATA_W-1:0] last_f_data, last_d_data;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .clear_n(clear_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_dataOutput(mem_dataOutput), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        if (a == 32'h400) return 32'hA840_0010;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous memory: read data registered on the edge that ends a memRead cycle.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_memRead) mem_dataOutput <= mem[mem_address];
            if (mem_memWrite) mem[mem_address] = mem_writeData;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Protocol invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (clear_n) begin
            check_output("strobe_overlap", 64'(mem_memRead & mem_memWrite), 64'(0));
            check_output("strobe_when_idle", 64'((mem_memRead | mem_memWrite) & ~busy), 64'(0));
            check_output("gnt_rvalid_clash",
                64'((f_gnt & f_rvalid) | (d_gnt & d_rvalid) | ((f_gnt | f_rvalid) & (d_gnt | d_rvalid))), 64'(0));
        end
    end

    // Issue one fetch and/or one data request from idle and compare observed timing with the model.
    task automatic apply_stimulus(input bit use_f, input bit use_d,
                                  input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] da,
                                  input bit we, input logic [DATA_W-1:0] wd);
        bit order[2];
        int n = 0;
        int t = 1;
        int exp_f_g = -1, exp_d_g = -1, exp_f_v = -1, exp_d_v = -1;
        int f_g = -1, d_g = -1, f_v = -1, d_v = -1;
        int f_gn = 0, d_gn = 0;
        logic [DATA_W-1:0] exp_f_data = '0, exp_d_data = '0;
        logic [DATA_W-1:0] f_obs = '0, d_obs = '0;

        if (use_f && use_d) begin
            order[0] = !fetch_next;
            order[1] = fetch_next;
            n = 2;
        end else if (use_f || use_d) begin
            order[0] = use_d;
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            if (order[k]) begin
                exp_d_g = t;
                if (we) begin
                    ref_mem[da] = wd;
                    t += 2;
                end else begin
                    exp_d_v = t + 2;
                    exp_d_data = ref_mem[da];
                    last_d_data = exp_d_data;
                    t += 3;
                end
            end else begin
                exp_f_g = t;
                exp_f_v = t + 2;
                exp_f_data = ref_mem[fa];
                last_f_data = exp_f_data;
                t += 3;
            end
        end
        if (n > 0) fetch_next = order[n-1];

        f_req = use_f; f_addr = fa;
        d_req = use_d; d_addr = da; d_we = we; d_wdata = wd;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (f_gnt) begin
                f_gn++;
                if (f_g < 0) f_g = c;
                check_output("f_gnt_address", 64'(mem_address), 64'(fa));
                check_output("f_gnt_memRead", 64'(mem_memRead), 64'(1));
                f_req = 1'b0;
            end
            if (d_gnt) begin
                d_gn++;
                if (d_g < 0) d_g = c;
                check_output("d_gnt_address", 64'(mem_address), 64'(da));
                check_output("d_gnt_memWrite", 64'(mem_memWrite), 64'(we));
                check_output("d_gnt_memRead", 64'(mem_memRead), 64'(!we));
                if (we) check_output("d_gnt_writeData", 64'(mem_writeData), 64'(wd));
                d_req = 1'b0;
            end
            if (f_rvalid) begin f_v = c; f_obs = f_rdata; end
            if (d_rvalid) begin d_v = c; d_obs = d_rdata; end
        end

        check_output("f_gnt_cycle", 64'(f_g), 64'(exp_f_g));
        check_output("d_gnt_cycle", 64'(d_g), 64'(exp_d_g));
        check_output("f_gnt_count", 64'(f_gn), 64'(use_f ? 1 : 0));
        check_output("d_gnt_count", 64'(d_gn), 64'(use_d ? 1 : 0));
        check_output("f_rvalid_cycle", 64'(f_v), 64'(exp_f_v));
        check_output("d_rvalid_cycle", 64'(d_v), 64'(exp_d_v));
        if (exp_f_v >= 0) check_output("f_rdata", 64'(f_obs), 64'(exp_f_data));
        if (exp_d_v >= 0) check_output("d_rdata", 64'(d_obs), 64'(exp_d_data));
        check_output("f_rdata_hold", 64'(f_rdata), 64'(last_f_data));
        check_output("d_rdata_hold", 64'(d_rdata), 64'(last_d_data));
        check_output("busy_after", 64'(busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wv;
        int kind;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        fetch_next  = 1'b1;
        last_f_data = '0;
        last_d_data = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_output("rst_f_gnt", 64'(f_gnt), 64'(0));
        check_output("rst_d_gnt", 64'(d_gnt), 64'(0));
        check_output("rst_f_rvalid", 64'(f_rvalid), 64'(0));
        check_output("rst_d_rvalid", 64'(d_rvalid), 64'(0));
        check_output("rst_memRead", 64'(mem_memRead), 64'(0));
        check_output("rst_memWrite", 64'(mem_memWrite), 64'(0));
        check_output("rst_address", 64'(mem_address), 64'(0));
        check_output("rst_writeData", 64'(mem_writeData), 64'(0));
        check_output("rst_f_rdata", 64'(f_rdata), 64'(0));
        check_output("rst_d_rdata", 64'(d_rdata), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        clear_n = 1'b1;
        step();

        // Directed fetch, then data write followed by a read of the same word.
        apply_stimulus(1'b1, 1'b0, 12'h400, 12'h000, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 12'h000, 12'h010, 1'b1, 32'h1);
        apply_stimulus(1'b0, 1'b1, 12'h000, 12'h010, 1'b0, 32'h0);

        // Reset while a fetch read sits in WAIT aborts it.
        f_req = 1'b1; f_addr = 12'h020;
        step();
        check_output("abort_gnt", 64'(f_gnt), 64'(1));
        f_req = 1'b0;
        step();
        check_output("abort_busy_wait", 64'(busy), 64'(1));
        clear_n = 1'b0;
        #1;
        check_output("abort_memRead", 64'(mem_memRead), 64'(0));
        check_output("abort_memWrite", 64'(mem_memWrite), 64'(0));
        check_output("abort_busy", 64'(busy), 64'(0));
        check_output("abort_f_rdata", 64'(f_rdata), 64'(0));
        check_output("abort_d_rdata", 64'(d_rdata), 64'(0));
        step();
        clear_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_output("abort_no_rvalid", 64'(f_rvalid), 64'(0));
        end
        fetch_next  = 1'b1;
        last_f_data = '0;
        last_d_data = '0;

        // Both ports requesting: grants must alternate starting with fetch.
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 1'b1, 12'($urandom_range(0, 15)), 12'($urandom_range(0, 15)), 1'b0, 32'h0);

        // Back-to-back data writes: one memWrite every second cycle.
        d_req = 1'b1; d_we = 1'b1;
        d_addr = 12'($urandom_range(0, 15)); d_wdata = $urandom;
        for (int c = 1; c <= 10; c++) begin
            step();
            check_output("b2b_memWrite", 64'(mem_memWrite), 64'(c % 2));
            check_output("b2b_d_gnt", 64'(d_gnt), 64'(c % 2));
            check_output("b2b_memRead", 64'(mem_memRead), 64'(0));
            if (d_gnt) begin
                check_output("b2b_address", 64'(mem_address), 64'(d_addr));
                check_output("b2b_writeData", 64'(mem_writeData), 64'(d_wdata));
                ref_mem[d_addr] = d_wdata;
                wa = 12'($urandom_range(0, 15));
                wv = $urandom;
                d_addr = wa; d_wdata = wv;
            end
            if (c == 10) d_req = 1'b0;
        end
        d_we = 1'b0;
        fetch_next = 1'b1;
        step();

        // Randomized mix of fetch, data read/write and contended requests.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            apply_stimulus(kind != 1, kind != 0,
                           12'($urandom_range(0, 15)), 12'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory word / instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clear_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port f_req  input  1  fetch-port read request, held until f_gnt seen.
REQ-006 SHALL have port f_addr  input  ADDR_W  fetch read address, stable while f_req high.
REQ-007 SHALL have port f_gnt  output  1  fetch request accepted, one-cycle pulse.
REQ-008 SHALL have port f_rvalid  output  1  f_rdata valid, one-cycle pulse.
REQ-009 SHALL have port f_rdata  output  DATA_W  fetch read data.
REQ-010 SHALL have port d_req  input  1  data-port request, held until d_gnt seen.
REQ-011 SHALL have port d_we  input  1  data-port write (1) / read (0), stable while d_req high.
REQ-012 SHALL have port d_addr  input  ADDR_W  data-port address.
REQ-013 SHALL have port d_wdata  input  DATA_W  data-port write data.
REQ-014 SHALL have port d_gnt  output  1  data request accepted, one-cycle pulse.
REQ-015 SHALL have port d_rvalid  output  1  d_rdata valid, one-cycle pulse (reads only).
REQ-016 SHALL have port d_rdata  output  DATA_W  data-port read data.
REQ-017 SHALL have port mem_address  output  ADDR_W  address to memory.
REQ-018 SHALL have port mem_writeData  output  DATA_W  write data to memory.
REQ-019 SHALL have port mem_memRead  output  1  memory read strobe.
REQ-020 SHALL have port mem_memWrite  output  1  memory write strobe.
REQ-021 SHALL have port mem_dataOutput  input  DATA_W  memory read data, registered by memory on the edge ending a memRead cycle.
REQ-022 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT; all outputs registered except busy (decoded from state).
REQ-024 IDLE: at an edge with f_req or d_req high, SHALL latch winner's address/data/we/port-id, drive mem_* from those latches, go to ISSUE; no request -> stay IDLE.
REQ-025 Arbitration SHALL be round-robin: single requester wins; both requesting -> port not granted last wins; after reset fetch wins first tie.
REQ-026 ISSUE (exactly one cycle): SHALL assert winner's gnt, assert exactly one of mem_memRead (fetch or d_we=0) / mem_memWrite (d_we=1); next state WAIT for reads, IDLE for writes.
REQ-027 WAIT (exactly one cycle): strobes low; at end edge SHALL capture mem_dataOutput into winner's rdata and pulse winner's rvalid in following cycle; next state IDLE.
REQ-028 Read latency SHALL be 3 cycles from edge sampling req to rvalid high; write occupies memory 2 cycles from req sample to IDLE.
REQ-029 mem_memRead and mem_memWrite SHALL never be high together and SHALL be low outside ISSUE.
REQ-030 Requests SHALL only be sampled in IDLE; req held during ISSUE/WAIT SHALL be ignored; requester drops req after the edge where gnt=1.
REQ-031 rvalid pulse cycle coincides with IDLE; a new request sampled in that cycle SHALL be accepted (back-to-back throughput: one read per 3 cycles, one write per 2).
REQ-032 rdata_x SHALL hold last captured value until next read for that port; mem_address/mem_writeData SHALL hold last issued values when idle.
REQ-033 gnt and rvalid for a port SHALL never both pulse in one cycle; at most one port's gnt/rvalid high per cycle.

Reset
REQ-034 clear_n low SHALL asynchronously force state IDLE, all gnt/rvalid/strobes 0, mem_address, mem_writeData, f_rdata, d_rdata 0, round-robin pointer to "fetch next".
REQ-035 Reset during ISSUE or WAIT SHALL abort the access: strobes drop immediately, no rvalid issued; first edge after release with req high SHALL start arbitration normally.

Verification
REQ-036 Fetch only: f_req=1, f_addr=0x400, memory holds 0xA8400010 -> f_gnt at cycle 1, mem_memRead=1 mem_address=0x400 same cycle, f_rvalid at cycle 3 with f_rdata=0xA8400010.
REQ-037 Data write then read: d_we=1 d_addr=0x010 d_wdata=0x1, then d_we=0 d_addr=0x010 -> one memWrite cycle, then d_rvalid with d_rdata=0x1.
REQ-038 Simultaneous f_req and d_req after reset, both held and re-raised -> grants alternate f,d,f,d; neither port granted twice in a row while the other waits.
REQ-039 clear_n low during WAIT of fetch read -> strobes 0 at once, no f_rvalid, busy=0, rdata=0.
REQ-040 Continuous d_req writes -> mem_memWrite every 2nd cycle, mem_memRead never high, strobes never overlap (assertion throughout all tests).
